// File: rtl/ram_bist.sv
// ram_bist: PSRAM write/read-back self-test engine driving memCtrl's request port.
// Optional memCtrl watchdog: define RAM_BIST_TIMEOUT_EN (adds the o_timeout port).
module ram_bist #(
  parameter int unsigned        ADDR_W        = 24,
  parameter int unsigned        DATA_W        = 8,
  parameter logic [ADDR_W-1:0]  START_ADDR    = 24'h1,
  parameter logic [ADDR_W-1:0]  END_ADDR      = 24'd4096000,
  parameter int unsigned        STARTUP_DELAY = 50000,
  parameter bit                 STOP_ON_FAIL  = 1'b1,
  parameter int unsigned        TIMEOUT       = 1024
) (
  input  logic              clkSys,
  input  logic              rst,
  input  logic              i_start,
  input  logic [1:0]        i_mode,
  output logic              o_cs_n,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_dataToWrite,
  input  logic [DATA_W-1:0] i_dataRead,
  input  logic              i_busy,
  input  logic              i_dataReady,
  output logic              o_done,
  output logic              o_pass,
  output logic [15:0]       o_errCount,
  output logic [ADDR_W-1:0] o_failAddr,
  output logic [DATA_W-1:0] o_failData,
`ifdef RAM_BIST_TIMEOUT_EN
  output logic              o_timeout,
`endif
  output logic [3:0]        o_state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_DELAY = 4'd1, S_WR_REQ = 4'd2, S_WR_WAIT = 4'd3, S_RD_REQ = 4'd4,
    S_RD_WAIT = 4'd5, S_CHECK = 4'd6, S_NEXT = 4'd7, S_DONE = 4'd8
  } state_t;

  // One counter serves both the power-up delay and the memCtrl wait watchdog.
  localparam int unsigned CNT_MAX = (STARTUP_DELAY > TIMEOUT) ? STARTUP_DELAY : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  function automatic logic [DATA_W-1:0] f_pat(input logic [1:0] m, input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    case (m)
      2'd0:    for (int i = 0; i < int'(DATA_W); i++) v[i] = i[0];
      2'd1:    v = DATA_W'(a);
      2'd2:    v = ~DATA_W'(a);
      default: v = DATA_W'(1) << (a % ADDR_W'(DATA_W));
    endcase
    return v;
  endfunction

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [1:0]          r_mode, w_mode;
  logic                r_cs_n, w_cs_n, r_write, w_write;
  logic [ADDR_W-1:0]   r_address, w_address, r_failAddr, w_failAddr;
  logic [DATA_W-1:0]   r_wdata, w_wdata, r_rdData, w_rdData, r_failData, w_failData;
  logic [15:0]         r_err, w_err, w_errInc;
  logic                r_done, w_done, r_pass, w_pass, w_mis;
`ifdef RAM_BIST_TIMEOUT_EN
  logic                r_to, w_to, w_tmo;
`endif

  always_comb begin
    w_next     = r_state;
    w_cnt      = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    w_addr     = r_addr;
    w_mode     = r_mode;
    w_cs_n     = 1'b1;
    w_write    = r_write;
    w_address  = r_address;
    w_wdata    = r_wdata;
    w_rdData   = r_rdData;
    w_err      = r_err;
    w_errInc   = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
    w_failAddr = r_failAddr;
    w_failData = r_failData;
    w_mis      = (r_rdData != f_pat(r_mode, r_addr));
`ifdef RAM_BIST_TIMEOUT_EN
    w_to       = r_to;
    w_tmo      = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: if (i_start) begin
        w_next     = S_DELAY;
        w_cnt      = '0;
        w_addr     = START_ADDR;
        w_mode     = i_mode;
        w_err      = '0;
        w_failAddr = '0;
        w_failData = '0;
`ifdef RAM_BIST_TIMEOUT_EN
        w_to       = 1'b0;
`endif
      end
      S_DELAY: if (r_cnt >= CNT_W'(STARTUP_DELAY - 1)) w_next = S_WR_REQ;
      S_WR_REQ: if (!i_busy) begin
        w_cs_n    = 1'b0;
        w_write   = 1'b1;
        w_address = r_addr;
        w_wdata   = f_pat(r_mode, r_addr);
        w_cnt     = '0;
        w_next    = S_WR_WAIT;
      end
      // r_cnt==0 is the strobe cycle: memCtrl has not raised busy yet.
      S_WR_WAIT: begin
        if (r_cnt != '0 && !i_busy) w_next = S_RD_REQ;
`ifdef RAM_BIST_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT - 1)) w_tmo = 1'b1;
`endif
      end
      S_RD_REQ: if (!i_busy) begin
        w_cs_n    = 1'b0;
        w_write   = 1'b0;
        w_address = r_addr;
        w_cnt     = '0;
        w_next    = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_dataReady && !i_busy) begin
          w_rdData = i_dataRead;
          w_next   = S_CHECK;
        end
`ifdef RAM_BIST_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT - 1)) w_tmo = 1'b1;
`endif
      end
      S_CHECK: begin
        if (w_mis) begin
          w_err = w_errInc;
          if (r_err == '0) begin
            w_failAddr = r_addr;
            w_failData = r_rdData;
          end
        end
        w_next = ((w_mis && STOP_ON_FAIL) || r_addr == END_ADDR) ? S_DONE : S_NEXT;
      end
      S_NEXT: begin
        w_addr = r_addr + 1'b1;
        w_next = S_WR_REQ;
      end
      default: w_next = S_IDLE;
    endcase
`ifdef RAM_BIST_TIMEOUT_EN
    if (w_tmo) begin
      w_next     = S_DONE;
      w_to       = 1'b1;
      w_err      = w_errInc;
      w_failAddr = r_addr;
      w_failData = '0;
    end
    w_done = (w_next == S_DONE);
    w_pass = w_done && (w_err == '0) && !w_to;
`else
    w_done = (w_next == S_DONE);
    w_pass = w_done && (w_err == '0);
`endif
  end

  always_ff @(posedge clkSys or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_mode     <= '0;
      r_cs_n     <= 1'b1;
      r_write    <= 1'b0;
      r_address  <= '0;
      r_wdata    <= '0;
      r_rdData   <= '0;
      r_err      <= '0;
      r_failAddr <= '0;
      r_failData <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
`ifdef RAM_BIST_TIMEOUT_EN
      r_to       <= 1'b0;
`endif
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt;
      r_addr     <= w_addr;
      r_mode     <= w_mode;
      r_cs_n     <= w_cs_n;
      r_write    <= w_write;
      r_address  <= w_address;
      r_wdata    <= w_wdata;
      r_rdData   <= w_rdData;
      r_err      <= w_err;
      r_failAddr <= w_failAddr;
      r_failData <= w_failData;
      r_done     <= w_done;
      r_pass     <= w_pass;
`ifdef RAM_BIST_TIMEOUT_EN
      r_to       <= w_to;
`endif
    end
  end

  assign o_cs_n        = r_cs_n;
  assign o_write       = r_write;
  assign o_address     = r_address;
  assign o_dataToWrite = r_wdata;
  assign o_done        = r_done;
  assign o_pass        = r_pass;
  assign o_errCount    = r_err;
  assign o_failAddr    = r_failAddr;
  assign o_failData    = r_failData;
  assign o_state       = r_state;
`ifdef RAM_BIST_TIMEOUT_EN
  assign o_timeout     = r_to;
`endif

endmodule

// File: tb/tb_ram_bist.sv
// Bench: two ram_bist instances (STOP_ON_FAIL=0/END=10 and STOP_ON_FAIL=1/END=16) on a
// random-latency memCtrl model with an optional stuck-at-1 fault, checked against a request-list model.
module tb_ram_bist;
  logic clkSys;
  initial clkSys = 1'b0;
  always #5 clkSys = ~clkSys;

  logic        rst, start;
  logic [1:0]  mode;
  logic        cs_n[2], wr[2], busy[2], rdy[2], done[2], pass[2];
  logic [23:0] addr[2], fa[2];
  logic [7:0]  wdat[2], rdat[2], fd[2];
  logic [15:0] errc[2];
  logic [3:0]  st[2];
`ifdef RAM_BIST_TIMEOUT_EN
  logic        tmo[2];
`endif

  int          nvec = 0, nfail = 0;
  logic [32:0] expq[2][$];
  logic [7:0]  mem[2][64];
  logic [7:0]  rv[2];
  int          bl[2], nreq[2], exp_err[2], exp_fa[2], exp_fd[2];
  bit          rp[2], prev_s[2];
  bit          fen, chk_run;
  int          fadr, fbit;

  ram_bist #(.ADDR_W(24), .DATA_W(8), .START_ADDR(24'h1), .END_ADDR(24'd10),
             .STARTUP_DELAY(4), .STOP_ON_FAIL(1'b0)) u0 (
    .clkSys(clkSys), .rst(rst), .i_start(start), .i_mode(mode),
    .o_cs_n(cs_n[0]), .o_write(wr[0]), .o_address(addr[0]), .o_dataToWrite(wdat[0]),
    .i_dataRead(rdat[0]), .i_busy(busy[0]), .i_dataReady(rdy[0]),
    .o_done(done[0]), .o_pass(pass[0]), .o_errCount(errc[0]), .o_failAddr(fa[0]),
    .o_failData(fd[0]),
`ifdef RAM_BIST_TIMEOUT_EN
    .o_timeout(tmo[0]),
`endif
    .o_state(st[0]));

  ram_bist #(.ADDR_W(24), .DATA_W(8), .START_ADDR(24'h1), .END_ADDR(24'd16),
             .STARTUP_DELAY(4), .STOP_ON_FAIL(1'b1)) u1 (
    .clkSys(clkSys), .rst(rst), .i_start(start), .i_mode(mode),
    .o_cs_n(cs_n[1]), .o_write(wr[1]), .o_address(addr[1]), .o_dataToWrite(wdat[1]),
    .i_dataRead(rdat[1]), .i_busy(busy[1]), .i_dataReady(rdy[1]),
    .o_done(done[1]), .o_pass(pass[1]), .o_errCount(errc[1]), .o_failAddr(fa[1]),
    .o_failData(fd[1]),
`ifdef RAM_BIST_TIMEOUT_EN
    .o_timeout(tmo[1]),
`endif
    .o_state(st[1]));

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pat(int m, int a);
    logic [7:0] av;
    av = a[7:0];
    case (m)
      0:       return 8'hAA;
      1:       return av;
      2:       return ~av;
      default: return 8'(1 << (a % 8));
    endcase
  endfunction

  // Memory content as seen by a read: stored byte with the stuck-at-1 bit forced.
  function automatic logic [7:0] rd_val(int a, logic [7:0] v);
    return v | ((fen && a == fadr) ? 8'(1 << fbit) : 8'h00);
  endfunction

  // Expected request list and final result for one DUT.
  task automatic plan(int k, int last, bit stop, int m);
    logic [7:0] p, r;
    expq[k].delete();
    exp_err[k] = 0; exp_fa[k] = 0; exp_fd[k] = 0; nreq[k] = 0;
    for (int a = 1; a <= last; a++) begin
      p = pat(m, a);
      expq[k].push_back({1'b1, 24'(a), p});
      expq[k].push_back({1'b0, 24'(a), 8'h00});
      r = rd_val(a, p);
      if (r != p) begin
        if (exp_err[k] == 0) begin exp_fa[k] = a; exp_fd[k] = int'(r); end
        exp_err[k]++;
        if (stop) break;
      end
    end
  endtask

  // memCtrl model and per-cycle request checker.
  always @(negedge clkSys) begin
    for (int k = 0; k < 2; k++) begin
      rdy[k]  = 1'b0;
      rdat[k] = 8'($urandom);
      if (rst !== 1'b1) begin
        bl[k] = 0; rp[k] = 1'b0;
      end else if (cs_n[k] === 1'b0) begin
        logic [32:0] got, e;
        nvec++; nreq[k]++;
        got = {wr[k], addr[k], wr[k] ? wdat[k] : 8'h00};
        if (expq[k].size() == 0) begin
          nfail++;
          $display("FAIL req_dut%0d: unexpected request %0h", k, got);
        end else begin
          e = expq[k].pop_front();
          if (got !== e || prev_s[k]) begin
            nfail++;
            $display("FAIL req_dut%0d: got %0h (back-to-back=%0b) expected %0h", k, got, prev_s[k], e);
          end
        end
        if (wr[k]) mem[k][addr[k][5:0]] = wdat[k];
        else begin
          rp[k] = 1'b1;
          rv[k] = rd_val(int'(addr[k]), mem[k][addr[k][5:0]]);
        end
        bl[k] = int'($urandom_range(0, 4));
      end else if (bl[k] > 0) bl[k]--;
      else if (rp[k]) begin
        rdy[k] = 1'b1; rdat[k] = rv[k]; rp[k] = 1'b0;
      end
      busy[k]   = (bl[k] > 0);
      prev_s[k] = (rst === 1'b1) && (cs_n[k] === 1'b0);
      if (chk_run && expq[k].size() > 0) begin
        nvec++;
        if (done[k] !== 1'b0) begin
          nfail++;
          $display("FAIL early_done_dut%0d: o_done=%b with %0d requests outstanding", k, done[k], expq[k].size());
        end
      end
    end
  end

  task automatic chk_reset(int k);
    chk($sformatf("rst_cs_n%0d", k), 32'(cs_n[k]), 1);
    chk($sformatf("rst_write%0d", k), 32'(wr[k]), 0);
    chk($sformatf("rst_addr%0d", k), 32'(addr[k]), 0);
    chk($sformatf("rst_wdata%0d", k), 32'(wdat[k]), 0);
    chk($sformatf("rst_done%0d", k), 32'(done[k]), 0);
    chk($sformatf("rst_pass%0d", k), 32'(pass[k]), 0);
    chk($sformatf("rst_err%0d", k), 32'(errc[k]), 0);
    chk($sformatf("rst_faddr%0d", k), 32'(fa[k]), 0);
    chk($sformatf("rst_fdata%0d", k), 32'(fd[k]), 0);
    chk($sformatf("rst_state%0d", k), 32'(st[k]), 0);
  endtask

  task automatic pulse_start(int m);
    @(negedge clkSys); start = 1'b1; mode = 2'(m);
    @(negedge clkSys); start = 1'b0; mode = 2'($urandom); chk_run = 1'b1;
  endtask

  task automatic run(int m, bit fe, int fadr_i, int fbit_i, bit extra);
    int cyc;
    fen = fe; fadr = fadr_i; fbit = fbit_i;
    plan(0, 10, 1'b0, m);
    plan(1, 16, 1'b1, m);
    pulse_start(m);
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 3000) begin
      @(negedge clkSys); cyc++;
      start = extra && cyc == 40 && !done[0] && !done[1];
    end
    start = 1'b0;
    @(negedge clkSys); chk_run = 1'b0;
    chk($sformatf("run_m%0d_finished", m), 32'(cyc < 3000), 1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("done%0d_m%0d", k, m), 32'(done[k]), 1);
      chk($sformatf("pass%0d_m%0d", k, m), 32'(pass[k]), 32'(exp_err[k] == 0));
      chk($sformatf("err%0d_m%0d", k, m), 32'(errc[k]), 32'(exp_err[k]));
      chk($sformatf("faddr%0d_m%0d", k, m), 32'(fa[k]), 32'(exp_fa[k]));
      chk($sformatf("fdata%0d_m%0d", k, m), 32'(fd[k]), 32'(exp_fd[k]));
      chk($sformatf("state%0d_m%0d", k, m), 32'(st[k]), 8);
      chk($sformatf("missing_req%0d_m%0d", k, m), 32'(expq[k].size()), 0);
      chk($sformatf("cs_idle%0d_m%0d", k, m), 32'(cs_n[k]), 1);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; mode = 2'd0; fen = 1'b0; fadr = 0; fbit = 0; chk_run = 1'b0;
    repeat (3) @(posedge clkSys);
    #1;
    chk_reset(0);
    chk_reset(1);
    @(negedge clkSys); rst = 1'b1;

    run(0, 1'b0, 0, 0, 1'b0);
    run(1, 1'b0, 0, 0, 1'b0);
    chk("m1_a8", 32'(mem[1][8]), 32'h08);
    chk("m1_a15", 32'(mem[1][15]), 32'h0F);
    run(3, 1'b0, 0, 0, 1'b1);
    chk("m3_a8", 32'(mem[1][8]), 32'h01);
    chk("m3_a10", 32'(mem[1][10]), 32'h04);
    chk("m3_a15", 32'(mem[1][15]), 32'h80);

    // Bit 3 stuck-at-1 at address 5, mode 1.
    run(1, 1'b1, 5, 3, 1'b0);
    chk("fault_err0", 32'(errc[0]), 1);
    chk("fault_faddr0", 32'(fa[0]), 5);
    chk("fault_fdata0", 32'(fd[0]), 32'h0D);
    chk("fault_pass0", 32'(pass[0]), 0);
    chk("fault_nreq0", 32'(nreq[0]), 20);
    chk("fault_nreq1", 32'(nreq[1]), 10);
    chk("fault_faddr1", 32'(fa[1]), 5);

    // Reset while u0 waits for read data at address 3.
    fen = 1'b0;
    plan(0, 10, 1'b0, 2);
    plan(1, 16, 1'b1, 2);
    pulse_start(2);
    cyc = 0;
    while (!(st[0] == 4'd5 && addr[0] == 24'd3 && cs_n[0] == 1'b1) && cyc < 3000) begin
      @(negedge clkSys); cyc++;
    end
    chk("reach_rd_wait_a3", 32'(cyc < 3000), 1);
    chk_run = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset(0);
    chk("midrst_cs_n1", 32'(cs_n[1]), 1);
    chk("midrst_state1", 32'(st[1]), 0);
    @(negedge clkSys); rst = 1'b1;
    expq[0].delete(); expq[1].delete();
    repeat (5) @(negedge clkSys);
    chk("post_rst_idle0", 32'(st[0]), 0);
    chk("post_rst_idle1", 32'(st[1]), 0);
    run(2, 1'b0, 0, 0, 1'b1);

    for (int i = 0; i < 6; i++)
      run(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 16)),
          int'($urandom_range(0, 7)), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
